// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage: bus widths,
// fetch FSM state encodings and the word-alignment mask for fetch addresses.
package stage_if_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord      = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] InstAlignMask = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_DROP = 2'b10
    } if_state_e;

    function automatic logic [InstAddrBus-1:0] align_pc(input logic [InstAddrBus-1:0] addr);
        return addr & InstAlignMask;
    endfunction

endpackage

// File: rtl/stage_if_queue.sv
// Synchronous FIFO for fetched {pc, inst} entries. The flush input overrides
// push and pop. An empty queue presents an all-zero head.
module if_queue #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));
    assign count_o = count_q;
    assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; the pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push_s = push_i && (!full_o || pop_i);
        do_pop_s  = pop_i && !empty_o;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rd_ptr_d = AW'(1'b0);
            wr_ptr_d = AW'(1'b0);
            count_d  = CW'(1'b0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= AW'(1'b0);
            wr_ptr_q <= AW'(1'b0);
            count_q  <= CW'(1'b0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a flushed push is not written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: fetch PC, req/ack memory interface, fetch FSM and IF/ID queue.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_drop_cnt counters.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    if_state_e                         state_q, state_d;
    logic [InstAddrBus-1:0]            fetch_pc_q, fetch_pc_d;
    logic [InstAddrBus-1:0]            mem_addr_q, mem_addr_d;
    logic                              mem_req_q, mem_req_d;
    logic                              push_s, pop_s, flush_s;
    logic                              q_full_s, q_empty_s;
    logic [CW-1:0]                     q_count_s;
    logic [InstAddrBus+InstBus-1:0]    q_head_s;

    if_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (InstAddrBus + InstBus)
    ) u_queue (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push_s),
        .wdata_i ({mem_addr_q, mem_rdata}),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .rdata_o (q_head_s),
        .full_o  (q_full_s),
        .empty_o (q_empty_s),
        .count_o (q_count_s)
    );

    assign pop_s    = !q_empty_s && !stall && !br_flag;
    assign if_valid = (q_count_s != CW'(1'b0));
    assign if_pc    = q_head_s[InstAddrBus+InstBus-1:InstBus];
    assign if_inst  = q_head_s[InstBus-1:0];
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Fetch FSM next-state: a redirect flushes the queue and retargets fetch_pc ahead of everything else.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push_s     = 1'b0;
        flush_s    = br_flag;
        unique case (state_q)
            IF_IDLE: begin
                if (br_flag) begin
                    fetch_pc_d = align_pc(br_target);
                end else if (!q_full_s) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = IF_WAIT;
                end else begin
                    state_d = IF_IDLE;
                end
            end
            IF_WAIT: begin
                if (br_flag) begin
                    fetch_pc_d = align_pc(br_target);
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = IF_IDLE;
                    end else begin
                        state_d = IF_DROP;
                    end
                end else if (mem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    mem_req_d  = 1'b0;
                    state_d    = IF_IDLE;
                end else begin
                    state_d = IF_WAIT;
                end
            end
            IF_DROP: begin
                if (br_flag) begin
                    fetch_pc_d = align_pc(br_target);
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                // The abandoned request still owns the bus until its ack arrives.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IF_IDLE;
                end else begin
                    state_d = IF_DROP;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IF_IDLE;
            end
        endcase
    end

    // Fetch FSM, fetch PC and memory-interface registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_drop_cnt_q;
    logic        drop_ack_s;

    assign drop_ack_s     = mem_ack && ((state_q == IF_DROP) || ((state_q == IF_WAIT) && br_flag));
    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_drop_cnt  = perf_drop_cnt_q;

    // Wrapping counters of accepted and discarded fetches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt_q <= 32'h0000_0000;
            perf_drop_cnt_q  <= 32'h0000_0000;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_q + {31'b0, push_s};
            perf_drop_cnt_q  <= perf_drop_cnt_q + {31'b0, drop_ack_s};
        end
    end
`else
    // This build carries no performance counters.
`endif

endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for stage_if; inputs change and outputs are
// sampled on the falling clock edge. Define IF_PERF_CNT_EN to check the counters.
module tb_stage_if;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_flag;
    logic [31:0] br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit auto_mem = 1'b0;

    stage_if #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_flag   (br_flag),
        .br_target (br_target),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench exceeded its time budget");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; the optional memory model acks any request one cycle after it appears.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (auto_mem) begin
            if (mem_req && !mem_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 32'hA5A5_0000;
            end else begin
                mem_ack = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        stall     = 1'b0;
        br_flag   = 1'b0;
        br_target = 32'h0000_0000;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;
        auto_mem  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        rst = 1'b0; stall = 1'b0; br_flag = 1'b0; br_target = 32'h0000_0000;
        mem_ack = 1'b0; mem_rdata = 32'h0000_0000;
        repeat (2) @(negedge clk);
        check("rst_req",   mem_req,  32'h0);
        check("rst_addr",  mem_addr, 32'h0);
        check("rst_valid", if_valid, 32'h0);
        check("rst_pc",    if_pc,    32'h0);
        check("rst_inst",  if_inst,  32'h0);
`ifdef IF_PERF_CNT_EN
        check("rst_pfetch", perf_fetch_cnt, 32'h0);
        check("rst_pdrop",  perf_drop_cnt,  32'h0);
`endif
        rst = 1'b1;

        // Streaming fetch, ack after one cycle, no stall
        auto_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s1_req",   mem_req,  32'h1);
            check("s1_addr",  mem_addr, 32'(4 * i));
            check("s1_nv",    if_valid, 32'h0);
            step();
            check("s1_gap",   mem_req,  32'h0);
            check("s1_valid", if_valid, 32'h1);
            check("s1_pc",    if_pc,    32'(4 * i));
            check("s1_inst",  if_inst,  32'hA5A5_0000 + 32'(4 * i));
        end

        // Stall fills the queue and blocks further requests
        do_reset();
        stall = 1'b1;
        auto_mem = 1'b1;
        repeat (4) step();
        step();
        check("s2_full_req",  mem_req,  32'h0);
        check("s2_full_val",  if_valid, 32'h1);
        check("s2_full_pc",   if_pc,    32'h0);
        step();
        check("s2_hold_req",  mem_req,  32'h0);
        check("s2_hold_pc",   if_pc,    32'h0);
        check("s2_hold_inst", if_inst,  32'hA5A5_0000);
        stall = 1'b0;
        step();
        check("s2_pop_pc",    if_pc,    32'h4);
        check("s2_pop_inst",  if_inst,  32'hA5A5_0004);
        check("s2_pop_req",   mem_req,  32'h0);
        step();
        check("s2_res_req",   mem_req,  32'h1);
        check("s2_res_addr",  mem_addr, 32'h8);
        check("s2_res_val",   if_valid, 32'h0);

        // Redirect during WAIT, late ack is discarded
        do_reset();
        step();
        check("s3_req",      mem_req,  32'h1);
        check("s3_addr",     mem_addr, 32'h0);
        br_flag = 1'b1; br_target = 32'h0000_0103;
        step();
        check("s3_drop_req", mem_req,  32'h1);
        check("s3_drop_adr", mem_addr, 32'h0);
        br_flag = 1'b0;
        repeat (2) step();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("s3_ack_req",  mem_req,  32'h0);
        check("s3_ack_val",  if_valid, 32'h0);
        mem_ack = 1'b0;
        step();
        check("s3_new_req",  mem_req,  32'h1);
        check("s3_new_addr", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        check("s3_valid",    if_valid, 32'h1);
        check("s3_pc",       if_pc,    32'h0000_0100);
        check("s3_inst",     if_inst,  32'h1234_5678);
`ifdef IF_PERF_CNT_EN
        check("s3_pfetch",   perf_fetch_cnt, 32'h1);
        check("s3_pdrop",    perf_drop_cnt,  32'h1);
`endif
        mem_ack = 1'b0;

        // Redirect in the same cycle as the ack
        step();
        check("s4_req",      mem_req,  32'h1);
        check("s4_addr",     mem_addr, 32'h0000_0104);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001;
        br_flag = 1'b1; br_target = 32'h0000_0200;
        step();
        check("s4_req_off",  mem_req,  32'h0);
        check("s4_val",      if_valid, 32'h0);
        check("s4_inst",     if_inst,  32'h0);
        mem_ack = 1'b0; br_flag = 1'b0;
        step();
        check("s4_new_req",  mem_req,  32'h1);
        check("s4_new_addr", mem_addr, 32'h0000_0200);
        check("s4_new_val",  if_valid, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("s4_pfetch",   perf_fetch_cnt, 32'h1);
        check("s4_pdrop",    perf_drop_cnt,  32'h2);
`endif

        // Reset while a request is outstanding, ack arriving during reset
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        check("s5_async_req",  mem_req,  32'h0);
        check("s5_async_addr", mem_addr, 32'h0);
        check("s5_async_val",  if_valid, 32'h0);
        @(negedge clk);
        check("s5_rst_req",    mem_req,  32'h0);
        check("s5_rst_pc",     if_pc,    32'h0);
        check("s5_rst_inst",   if_inst,  32'h0);
        rst = 1'b1;
        step();
        check("s5_first_req",  mem_req,  32'h1);
        check("s5_first_addr", mem_addr, 32'h0);
        check("s5_first_val",  if_valid, 32'h0);
        mem_ack = 1'b0;
        step();
        check("s5_wait_req",   mem_req,  32'h1);
        check("s5_wait_val",   if_valid, 32'h0);

        // PC wrap at the top of the address space, then redirect from IDLE
        br_flag = 1'b1; br_target = 32'hFFFF_FFFF;
        step();
        check("s6_drop_req", mem_req,  32'h1);
        br_flag = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        check("s6_ack_req",  mem_req,  32'h0);
        mem_ack = 1'b0;
        step();
        check("s6_top_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        step();
        check("s6_top_pc",   if_pc,    32'hFFFF_FFFC);
        check("s6_top_inst", if_inst,  32'h0000_0013);
        mem_ack = 1'b0;
        step();
        check("s6_wrap_req", mem_req,  32'h1);
        check("s6_wrap_adr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0033;
        step();
        check("s6_w_pc",     if_pc,    32'h0);
        check("s6_w_inst",   if_inst,  32'h0000_0033);
        mem_ack = 1'b0;
        br_flag = 1'b1; br_target = 32'h0000_0042;
        step();
        check("s6_idle_req", mem_req,  32'h0);
        check("s6_idle_val", if_valid, 32'h0);
        br_flag = 1'b0;
        step();
        check("s6_br_req",   mem_req,  32'h1);
        check("s6_br_addr",  mem_addr, 32'h0000_0040);
`ifdef IF_PERF_CNT_EN
        check("s6_pfetch",   perf_fetch_cnt, 32'h2);
        check("s6_pdrop",    perf_drop_cnt,  32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
